sal_cmd_sched: RTL and testbench

Parametrised DRAM command scheduler for the SAL controller family. It sits between the per-bank controllers and the DFI control path. It arbitrates among BK_CNT bank command requests using round-robin with an optional column-command-first priority, and inserts all-bank refreshes from an internal tREFI timer with a postponement debt counter. It replaces the fixed-bank-count, refresh-less scheduler path.

---
 rtl/sal_cmd_sched.sv | 158 +++++++++++++++
 tb/tb_sal_cmd_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_cmd_sched.sv
// DRAM command scheduler: round-robin bank arbitration with optional column-first
// priority, plus tREFI-driven all-bank refresh with a postponement debt counter.
module sal_cmd_sched #(
  parameter int BK_CNT        = 8,
  parameter int ADDR_W        = 14,
  parameter int T_REFI        = 780,
  parameter int T_RFC         = 26,
  parameter int MAX_DEBT      = 8,
  parameter int ROW_HIT_FIRST = 1,
  localparam int BK_W         = $clog2(BK_CNT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BK_CNT-1:0]        bk_req_valid,
  input  logic [2*BK_CNT-1:0]      bk_req_cmd,
  input  logic [ADDR_W*BK_CNT-1:0] bk_req_addr,
  output logic [BK_CNT-1:0]        bk_req_ready,
  input  logic [BK_CNT-1:0]        bk_idle,
  output logic                     cmd_valid,
  output logic [2:0]               cmd_code,
  output logic [BK_W-1:0]          cmd_bk,
  output logic [ADDR_W-1:0]        cmd_addr,
  output logic [3:0]               ref_debt,
  output logic                     ref_busy
);

  localparam int REFI_W = $clog2(T_REFI);
  localparam int RFC_W  = $clog2(T_RFC);
  localparam logic [3:0] DEBT_MAX  = 4'(MAX_DEBT);
  localparam logic [3:0] DEBT_HALF = 4'(MAX_DEBT / 2);
  localparam logic [2:0] CODE_NOP = 3'd0;
  localparam logic [2:0] CODE_REF = 3'd5;

  typedef enum logic [1:0] {NORMAL, REF_DRAIN, REF_ISSUE, REF_RFC} state_t;

  state_t              state, state_nxt;
  logic [BK_W-1:0]     rr_ptr;
  logic [REFI_W-1:0]   ref_cnt;
  logic [RFC_W-1:0]    rfc_cnt;
  logic [BK_CNT-1:0]   is_rw, is_pre, elig, grant;
  logic [BK_W-1:0]     grant_idx;
  logic                grant_any;
  logic [1:0]          sel_cmd;
  logic [ADDR_W-1:0]   sel_addr;
  logic                ref_wrap, ref_issue;

  always_comb begin
    is_rw  = '0;
    is_pre = '0;
    for (int unsigned i = 0; i < BK_CNT; i++) begin
      is_rw[i]  = (bk_req_cmd[2*i +: 2] == 2'd1) || (bk_req_cmd[2*i +: 2] == 2'd2);
      is_pre[i] = (bk_req_cmd[2*i +: 2] == 2'd3);
    end
  end

  always_comb begin
    elig = '0;
    case (state)
      NORMAL: begin
        elig = bk_req_valid;
        if (ROW_HIT_FIRST != 0 && |(bk_req_valid & is_rw))
          elig = bk_req_valid & is_rw;
      end
      REF_DRAIN: elig = bk_req_valid & is_pre;
      default:   elig = '0;
    endcase
  end

  // Scan starts at rr_ptr; BK_W-bit addition wraps modulo BK_CNT.
  always_comb begin
    logic [BK_W-1:0] idx;
    idx       = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int unsigned k = 0; k < BK_CNT; k++) begin
      idx = rr_ptr + BK_W'(k);
      if (!grant_any && elig[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    if (grant_any)
      grant[grant_idx] = 1'b1;
  end

  assign bk_req_ready = grant & {BK_CNT{~rst}};
  assign sel_cmd      = bk_req_cmd[2*grant_idx +: 2];
  assign sel_addr     = bk_req_addr[ADDR_W*grant_idx +: ADDR_W];
  assign ref_wrap     = (ref_cnt == REFI_W'(T_REFI - 1));
  assign ref_issue    = (state == REF_ISSUE);
  assign ref_busy     = (state != NORMAL);

  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL:
        if (ref_debt != '0 && (bk_req_valid == '0 || ref_debt >= DEBT_HALF))
          state_nxt = REF_DRAIN;
      REF_DRAIN:
        if (&bk_idle && !grant_any)
          state_nxt = REF_ISSUE;
      REF_ISSUE:
        state_nxt = REF_RFC;
      REF_RFC:
        if (rfc_cnt == '0)
          state_nxt = (ref_debt >= DEBT_HALF) ? REF_DRAIN : NORMAL;
      default:
        state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= NORMAL;
      rr_ptr    <= '0;
      ref_cnt   <= '0;
      rfc_cnt   <= '0;
      ref_debt  <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= CODE_NOP;
      cmd_bk    <= '0;
      cmd_addr  <= '0;
    end else begin
      state   <= state_nxt;
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;

      // A wrap landing on the issue cycle cancels the decrement.
      if (ref_wrap && !ref_issue && ref_debt < DEBT_MAX)
        ref_debt <= ref_debt + 4'd1;
      else if (ref_issue && !ref_wrap)
        ref_debt <= ref_debt - 4'd1;

      if (ref_issue)
        rfc_cnt <= RFC_W'(T_RFC - 1);
      else if (state == REF_RFC && rfc_cnt != '0)
        rfc_cnt <= rfc_cnt - 1'b1;

      if (grant_any)
        rr_ptr <= grant_idx + BK_W'(1);

      cmd_valid <= 1'b0;
      cmd_code  <= CODE_NOP;
      cmd_bk    <= '0;
      cmd_addr  <= '0;
      if (ref_issue) begin
        cmd_valid <= 1'b1;
        cmd_code  <= CODE_REF;
      end else if (grant_any) begin
        cmd_valid <= 1'b1;
        cmd_code  <= {1'b0, sel_cmd} + 3'd1;
        cmd_bk    <= grant_idx;
        cmd_addr  <= (sel_cmd == 2'd3) ? '0 : sel_addr;
      end
    end
  end

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Directed bench for sal_cmd_sched: arbitration order, column-first priority,
// refresh insertion, postponement, debt saturation and reset abort.
module tb_sal_cmd_sched;

  localparam int BK_CNT = 8;
  localparam int ADDR_W = 14;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [BK_CNT-1:0]        bk_req_valid;
  logic [2*BK_CNT-1:0]      bk_req_cmd;
  logic [ADDR_W*BK_CNT-1:0] bk_req_addr;
  logic [BK_CNT-1:0]        bk_idle;

  logic [BK_CNT-1:0] ready, rr_ready;
  logic              cmd_valid, rr_cmd_valid;
  logic [2:0]        cmd_code, rr_cmd_code;
  logic [2:0]        cmd_bk, rr_cmd_bk;
  logic [ADDR_W-1:0] cmd_addr, rr_cmd_addr;
  logic [3:0]        ref_debt, rr_ref_debt;
  logic              ref_busy, rr_ref_busy;

  int n_checks = 0;
  int n_errors = 0;
  int n = 0;
  int exp_debt [6] = '{7, 7, 6, 5, 4, 3};

  always #5 clk = ~clk;
  always @(posedge clk) if (!rst) n <= n + 1;

  sal_cmd_sched #(.BK_CNT(8), .ADDR_W(14), .T_REFI(100), .T_RFC(10),
                  .MAX_DEBT(8), .ROW_HIT_FIRST(1)) u_dut (
    .clk(clk), .rst(rst), .bk_req_valid(bk_req_valid), .bk_req_cmd(bk_req_cmd),
    .bk_req_addr(bk_req_addr), .bk_req_ready(ready), .bk_idle(bk_idle),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bk(cmd_bk),
    .cmd_addr(cmd_addr), .ref_debt(ref_debt), .ref_busy(ref_busy));

  sal_cmd_sched #(.BK_CNT(8), .ADDR_W(14), .T_REFI(100), .T_RFC(10),
                  .MAX_DEBT(8), .ROW_HIT_FIRST(0)) u_dut_rr (
    .clk(clk), .rst(rst), .bk_req_valid(bk_req_valid), .bk_req_cmd(bk_req_cmd),
    .bk_req_addr(bk_req_addr), .bk_req_ready(rr_ready), .bk_idle(bk_idle),
    .cmd_valid(rr_cmd_valid), .cmd_code(rr_cmd_code), .cmd_bk(rr_cmd_bk),
    .cmd_addr(rr_cmd_addr), .ref_debt(rr_ref_debt), .ref_busy(rr_ref_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int target);
    while (n < target) tick();
    check("sync", 32'(n), 32'(target));
  endtask

  task automatic set_all_rd();
    for (int i = 0; i < BK_CNT; i++) begin
      bk_req_cmd[2*i +: 2]         = 2'd1;
      bk_req_addr[ADDR_W*i +: ADDR_W] = 14'(i * 16 + 3);
    end
    bk_req_valid = '1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bk_idle     = '1;
    bk_req_cmd  = '0;
    bk_req_addr = '0;
    set_all_rd();
    repeat (3) tick();
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_valid", 32'(cmd_valid), 32'h0);
    check("rst_code", 32'(cmd_code), 32'h0);
    check("rst_debt", 32'(ref_debt), 32'h0);
    check("rst_busy", 32'(ref_busy), 32'h0);
    rst = 1'b0;
    #1;

    // round-robin over all banks with RD, wrapping back to bank 0
    for (int k = 0; k < 9; k++) begin
      check("t1_ready", 32'(ready), 32'(1 << (k % 8)));
      tick();
      check("t1_valid", 32'(cmd_valid), 32'h1);
      check("t1_code", 32'(cmd_code), 32'h2);
      check("t1_bk", 32'(cmd_bk), 32'(k % 8));
      check("t1_addr", 32'(cmd_addr), 32'((k % 8) * 16 + 3));
    end
    bk_req_valid = '0;
    #1;
    check("idle_ready", 32'(ready), 32'h0);
    tick();
    check("idle_valid", 32'(cmd_valid), 32'h0);
    check("idle_code", 32'(cmd_code), 32'h0);

    // bank 2 ACT vs bank 5 RD
    bk_req_cmd[5:4]   = 2'd0;
    bk_req_addr[41:28] = 14'h123;
    bk_req_addr[83:70] = 14'h055;
    bk_req_valid = 8'b0010_0100;
    #1;
    check("prio_ready", 32'(ready), 32'h20);
    check("rr_ready", 32'(rr_ready), 32'h04);
    tick();
    check("prio_code", 32'(cmd_code), 32'h2);
    check("prio_bk", 32'(cmd_bk), 32'h5);
    check("prio_addr", 32'(cmd_addr), 32'h055);
    check("rr_code", 32'(rr_cmd_code), 32'h1);
    check("rr_bk", 32'(rr_cmd_bk), 32'h2);
    check("rr_addr", 32'(rr_cmd_addr), 32'h123);
    bk_req_valid = 8'b0000_0100;
    #1;
    check("prio2_ready", 32'(ready), 32'h04);
    tick();
    check("prio2_code", 32'(cmd_code), 32'h1);
    check("prio2_bk", 32'(cmd_bk), 32'h2);
    bk_req_valid = '0;

    // idle-bus refresh
    wait_to(99);
    check("t3_debt0", 32'(ref_debt), 32'h0);
    tick();
    check("t3_debt1", 32'(ref_debt), 32'h1);
    check("t3_busy0", 32'(ref_busy), 32'h0);
    tick();
    check("t3_drain", 32'(ref_busy), 32'h1);
    tick();
    check("t3_issue_busy", 32'(ref_busy), 32'h1);
    check("t3_issue_valid", 32'(cmd_valid), 32'h0);
    tick();
    check("t3_ref_valid", 32'(cmd_valid), 32'h1);
    check("t3_ref_code", 32'(cmd_code), 32'h5);
    check("t3_ref_bk", 32'(cmd_bk), 32'h0);
    check("t3_ref_addr", 32'(cmd_addr), 32'h0);
    check("t3_debt_back", 32'(ref_debt), 32'h0);
    set_all_rd();
    for (int j = 0; j < 10; j++) begin
      #1;
      check("rfc_ready", 32'(ready), 32'h0);
      check("rfc_busy", 32'(ref_busy), 32'h1);
      tick();
    end
    check("post_rfc_ready", 32'(ready), 32'h08);
    check("post_rfc_busy", 32'(ref_busy), 32'h0);

    // postponement under continuous RD traffic
    wait_to(499);
    check("t4_debt3", 32'(ref_debt), 32'h3);
    check("t4_busy", 32'(ref_busy), 32'h0);
    check("t4_valid", 32'(cmd_valid), 32'h1);
    tick();
    check("t4_debt4", 32'(ref_debt), 32'h4);
    check("t4_busy_n", 32'(ref_busy), 32'h0);
    tick();
    check("t4_drain", 32'(ref_busy), 32'h1);
    bk_idle = '0;
    bk_req_cmd[13:12] = 2'd3;
    #1;
    check("drain_pre_ready", 32'(ready), 32'h40);
    tick();
    check("drain_pre_code", 32'(cmd_code), 32'h4);
    check("drain_pre_bk", 32'(cmd_bk), 32'h6);
    check("drain_pre_addr", 32'(cmd_addr), 32'h0);
    bk_req_valid = 8'hBF;
    #1;
    check("drain_hold_ready", 32'(ready), 32'h0);
    tick();
    check("drain_hold_valid", 32'(cmd_valid), 32'h0);
    check("drain_hold_busy", 32'(ref_busy), 32'h1);
    wait_to(600);
    check("debt5", 32'(ref_debt), 32'h5);
    wait_to(1000);
    check("debt_sat", 32'(ref_debt), 32'h8);
    check("sat_busy", 32'(ref_busy), 32'h1);
    check("sat_valid", 32'(cmd_valid), 32'h0);

    // release banks; REFs repeat every 12 cycles while debt >= 4
    wait_to(1086);
    bk_idle = '1;
    #1;
    check("release_ready", 32'(ready), 32'h0);
    tick();
    check("release_issue_busy", 32'(ref_busy), 32'h1);
    check("release_issue_valid", 32'(cmd_valid), 32'h0);
    for (int r = 0; r < 6; r++) begin
      if (r > 0) begin
        wait_to(1087 + 12 * r);
        check("ref_gap_valid", 32'(cmd_valid), 32'h0);
      end
      wait_to(1088 + 12 * r);
      check("ref_seq_valid", 32'(cmd_valid), 32'h1);
      check("ref_seq_code", 32'(cmd_code), 32'h5);
      check("ref_seq_debt", 32'(ref_debt), 32'(exp_debt[r]));
    end
    wait_to(1157);
    check("seq_end_busy", 32'(ref_busy), 32'h1);
    wait_to(1158);
    check("seq_done_busy", 32'(ref_busy), 32'h0);
    check("seq_done_ready", 32'(ready), 32'h80);
    set_all_rd();

    // reset aborts refresh recovery
    wait_to(1200);
    check("t5_debt4", 32'(ref_debt), 32'h4);
    wait_to(1203);
    check("t5_ref_code", 32'(cmd_code), 32'h5);
    check("t5_debt3", 32'(ref_debt), 32'h3);
    wait_to(1205);
    check("t5_rfc_busy", 32'(ref_busy), 32'h1);
    rst = 1'b1;
    #1;
    check("t5_rst_ready", 32'(ready), 32'h0);
    tick();
    check("t5_valid", 32'(cmd_valid), 32'h0);
    check("t5_code", 32'(cmd_code), 32'h0);
    check("t5_bk", 32'(cmd_bk), 32'h0);
    check("t5_addr", 32'(cmd_addr), 32'h0);
    check("t5_debt", 32'(ref_debt), 32'h0);
    check("t5_busy", 32'(ref_busy), 32'h0);
    rst = 1'b0;
    #1;
    check("t5_resume_ready", 32'(ready), 32'h01);
    tick();
    check("t5_resume_code", 32'(cmd_code), 32'h2);
    check("t5_resume_bk", 32'(cmd_bk), 32'h0);
    check("t5_resume_addr", 32'(cmd_addr), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
